// File: rtl/gencon_param_pkg.sv
// gencon_param_pkg: shared state/operator encodings and the signed range check
package gencon_param_pkg;

    typedef enum logic [2:0] {
        S_ENTRY_A = 3'd0,
        S_OPER    = 3'd1,
        S_EXEC    = 3'd2,
        S_ENTRY_B = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_NEG  = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_MUL  = 3'd4
    } op_t;

    // True when v does not fit a w-bit two's complement value (w <= 32)
    function automatic logic out_of_range(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        return (v > hi) || (v < -hi - 64'sd1);
    endfunction

endpackage

// File: rtl/gencon_seq_mult.sv
// gencon_seq_mult: signed shift-add multiplier, one multiplier bit per cycle
module gencon_seq_mult #(
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  nRST,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0] ITER = CW'(DATA_W);

    logic [2*DATA_W-1:0] mcand, acc, addend;
    logic [DATA_W-1:0]   mplier;
    logic [CW-1:0]       cnt;
    logic                run;

    // The multiplier MSB carries negative weight, so its partial product is subtracted
    always_comb addend = !mplier[0] ? '0 : (cnt == LAST ? -mcand : mcand);

    // Load on start, then accumulate one shifted partial product per cycle
    always_ff @(posedge clk) begin
        if (!nRST || abort) begin
            run    <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            run    <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{DATA_W{a[DATA_W-1]}}, a};
            mplier <= b;
        end else if (done) begin
            run    <= 1'b0;
        end else if (run) begin
            acc    <= acc + addend;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
        end
    end

    assign done    = run && cnt == ITER;
    assign product = acc;

endmodule

// File: rtl/gencon_param.sv
// gencon_param: keypad calculator controller; GENCON_SATURATE_EN clamps out-of-range results
module gencon_param
    import gencon_param_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int MAX_DIGITS = 5
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic [3:0]        keypad_input,
    input  logic              read_input,
    input  logic [2:0]        operator_input,
    input  logic              equal_input,
    input  logic              clear_input,
    output logic              complete,
    output logic              busy,
    output logic              overflow,
    output logic [DATA_W-1:0] display_output,
    output logic [2:0]        tb_current_state
);
    localparam int W  = DATA_W;
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0]  MAXD   = CW'(MAX_DIGITS);
    localparam logic [W+3:0]   LIMPOS = {5'd0, {(W-1){1'b1}}};
    localparam logic [W+3:0]   LIMNEG = {4'd0, 1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]   MAGMIN = {1'b1, {(W-1){1'b0}}};
`ifdef GENCON_SATURATE_EN
    localparam logic [W-1:0]   SMAX   = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]   SMIN   = {1'b1, {(W-1){1'b0}}};
`endif

    state_t          state, nxt;
    op_t             op_q;
    logic [W-1:0]    mag, entry_val, a, b, res, res_n;
    logic            neg, touched, ovf, ovf_n;
    logic [CW-1:0]   cnt;
    logic [W+3:0]    mag_next;
    logic [2*W-1:0]  ax, bx, full, product;
    logic            digit_ok, can_digit, is_bin, is_neg, mul_start, mul_done;

    assign digit_ok  = read_input && keypad_input <= 4'd9;
    assign mag_next  = ({4'd0, mag} << 3) + ({4'd0, mag} << 1) + {{W{1'b0}}, keypad_input};
    assign can_digit = digit_ok && cnt < MAXD && mag_next <= (neg ? LIMNEG : LIMPOS);
    assign is_bin    = operator_input inside {3'd2, 3'd3, 3'd4};
    assign is_neg    = operator_input == 3'd1;
    assign entry_val = neg ? -mag : mag;
    assign mul_start = state == S_ENTRY_B && equal_input && !clear_input && op_q == OP_MUL;

    gencon_seq_mult #(.DATA_W(W)) u_mult (
        .clk     (clk),
        .nRST    (nRST),
        .start   (mul_start),
        .abort   (clear_input),
        .a       (a),
        .b       (entry_val),
        .done    (mul_done),
        .product (product)
    );

    // Full-width result, range check and the value that will be displayed
    always_comb begin
        ax    = {{W{a[W-1]}}, a};
        bx    = {{W{b[W-1]}}, b};
        full  = op_q == OP_MUL ? product : op_q == OP_SUB ? ax - bx : ax + bx;
        ovf_n = out_of_range(64'(signed'(full)), W);
`ifdef GENCON_SATURATE_EN
        res_n = !ovf_n ? full[W-1:0] : full[2*W-1] ? SMIN : SMAX;
`else
        res_n = full[W-1:0];
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (!nRST) state <= S_ENTRY_A;
        else       state <= nxt;
    end

    // Next-state logic; clear overrides everything
    always_comb begin
        nxt = state;
        if (clear_input) nxt = S_ENTRY_A;
        else case (state)
            S_ENTRY_A: nxt = is_bin ? S_OPER : S_ENTRY_A;
            S_OPER:    nxt = S_ENTRY_B;
            S_ENTRY_B: nxt = equal_input ? S_EXEC : S_ENTRY_B;
            S_EXEC:    nxt = (op_q != OP_MUL || mul_done) ? S_DONE : S_EXEC;
            S_DONE:    nxt = is_bin ? S_ENTRY_B : digit_ok ? S_ENTRY_A : S_DONE;
            default:   nxt = S_ENTRY_A;
        endcase
    end

    // Operand entry, operator latching and result capture
    always_ff @(posedge clk) begin
        if (!nRST || clear_input) begin
            mag     <= '0;
            neg     <= 1'b0;
            cnt     <= '0;
            touched <= 1'b0;
            a       <= '0;
            b       <= '0;
            op_q    <= OP_NONE;
            res     <= '0;
            ovf     <= 1'b0;
        end else case (state)
            S_ENTRY_A, S_ENTRY_B: begin
                if (state == S_ENTRY_B && equal_input) begin
                    b <= entry_val;
                end else if (is_bin) begin
                    if (state == S_ENTRY_A) begin
                        a    <= entry_val;
                        op_q <= op_t'(operator_input);
                    end else if (!touched) begin
                        op_q <= op_t'(operator_input);
                    end
                end else if (is_neg) begin
                    touched <= 1'b1;
                    if (!(neg && mag == MAGMIN)) neg <= ~neg;
                end else if (can_digit) begin
                    touched <= 1'b1;
                    mag     <= mag_next[W-1:0];
                    cnt     <= cnt + CW'(1);
                end
            end
            S_OPER: begin
                mag     <= '0;
                neg     <= 1'b0;
                cnt     <= '0;
                touched <= 1'b0;
            end
            S_EXEC: begin
                if (nxt == S_DONE) begin
                    res <= res_n;
                    ovf <= ovf_n;
                end
            end
            S_DONE: begin
                if (is_bin) begin
                    a       <= res;
                    op_q    <= op_t'(operator_input);
                    mag     <= '0;
                    neg     <= 1'b0;
                    cnt     <= '0;
                    touched <= 1'b0;
                    ovf     <= 1'b0;
                end else if (digit_ok) begin
                    mag     <= {{(W-4){1'b0}}, keypad_input};
                    neg     <= 1'b0;
                    cnt     <= CW'(1);
                    touched <= 1'b0;
                    ovf     <= 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Status and display outputs decoded from the current state
    always_comb begin
        complete         = state == S_DONE;
        busy             = state == S_EXEC;
        overflow         = state == S_DONE && ovf;
        display_output   = state == S_DONE ? res : entry_val;
        tb_current_state = state;
    end

endmodule

// File: tb/tb_gencon_param.sv
// tb_gencon_param: scoreboard bench for gencon_param (honours GENCON_SATURATE_EN)
module tb_gencon_param;

    typedef struct {
        logic [15:0] disp;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    logic [3:0]  keypad_input = '0;
    logic        read_input = 1'b0;
    logic [2:0]  operator_input = '0;
    logic        equal_input = 1'b0;
    logic        clear_input = 1'b0;
    logic        complete, busy, overflow;
    logic [15:0] display_output;
    logic [2:0]  tb_current_state;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic prev_c = 1'b0;

    gencon_param #(.DATA_W(16), .MAX_DIGITS(5)) dut (
        .clk              (clk),
        .nRST             (nRST),
        .keypad_input     (keypad_input),
        .read_input       (read_input),
        .operator_input   (operator_input),
        .equal_input      (equal_input),
        .clear_input      (clear_input),
        .complete         (complete),
        .busy             (busy),
        .overflow         (overflow),
        .display_output   (display_output),
        .tb_current_state (tb_current_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        keypad_input = d;
        read_input = 1'b1;
        tick();
        read_input = 1'b0;
    endtask

    task automatic oper(input logic [2:0] o);
        operator_input = o;
        tick();
        operator_input = 3'd0;
    endtask

    task automatic clr();
        clear_input = 1'b1;
        tick();
        clear_input = 1'b0;
    endtask

    task automatic enter(input int v);
        int m;
        int d[$];
        m = v < 0 ? -v : v;
        if (v < 0) oper(3'd1);
        do begin
            d.push_front(m % 10);
            m = m / 10;
        end while (m > 0);
        foreach (d[i]) key(4'(d[i]));
    endtask

    function automatic void model(input int a, input int b, input int opc,
                                  output logic [15:0] d, output logic o);
        longint f;
        f = opc == 2 ? longint'(a) + longint'(b) :
            opc == 3 ? longint'(a) - longint'(b) : longint'(a) * longint'(b);
        o = f > 32767 || f < -32768;
`ifdef GENCON_SATURATE_EN
        d = !o ? 16'(f) : f < 0 ? 16'h8000 : 16'h7fff;
`else
        d = 16'(f);
`endif
    endfunction

    task automatic finish_op(input int exp_busy);
        int n, nb;
        equal_input = 1'b1;
        tick();
        equal_input = 1'b0;
        n = 0;
        nb = 0;
        while (!complete && n < 60) begin
            nb += int'(busy);
            tick();
            n++;
        end
        chk("done_wait", complete, 1);
        chk("busy_cycles", nb, exp_busy);
    endtask

    task automatic run_op(input int a, input int opc, input int b, input int exp_busy);
        logic [15:0] ed;
        logic        eo;
        clr();
        enter(a);
        oper(3'(opc));
        tick();
        enter(b);
        model(a, b, opc, ed, eo);
        sbq.push_back('{ed, eo});
        finish_op(exp_busy);
    endtask

    // Scoreboard: each rising complete consumes one expected result
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (complete && !prev_c) begin
                if (sbq.size() == 0) chk("sb_unexpected", complete, 0);
                else begin
                    e = sbq.pop_front();
                    chk("res_disp", display_output, e.disp);
                    chk("res_ovf", overflow, e.ovf);
                end
            end
            prev_c = complete;
        end
    end

    initial begin
        repeat (3) tick();
        chk("rst_state", tb_current_state, 0);
        chk("rst_disp", display_output, 0);
        chk("rst_busy", busy, 0);
        chk("rst_complete", complete, 0);
        chk("rst_ovf", overflow, 0);
        nRST = 1'b1;
        tick();

        run_op(2, 2, 3, 1);
        run_op(-32768, 4, 1, 17);
        run_op(128, 4, 256, 17);
        key(4'd1);
        chk("ovf_drop", overflow, 0);
        chk("done_digit_state", tb_current_state, 0);
        run_op(-12, 4, 3000, 17);
        run_op(-7, 3, 9, 1);

        run_op(5, 3, 3, 1);
        oper(3'd1);
        chk("neg_in_done_disp", display_output, 2);
        chk("neg_in_done_cmp", complete, 1);
        oper(3'd2);
        chk("chain_state", tb_current_state, 3);
        chk("chain_cmp", complete, 0);
        key(4'd4);
        sbq.push_back('{16'd6, 1'b0});
        finish_op(1);
        key(4'd7);
        chk("fresh_state", tb_current_state, 0);
        chk("fresh_disp", display_output, 7);
        chk("fresh_cmp", complete, 0);

        clr();
        key(4'd9);
        oper(3'd2);
        tick();
        oper(3'd3);
        key(4'd4);
        oper(3'd4);
        sbq.push_back('{16'd5, 1'b0});
        finish_op(1);

        clr();
        enter(100);
        oper(3'd4);
        tick();
        enter(200);
        equal_input = 1'b1;
        tick();
        equal_input = 1'b0;
        repeat (5) tick();
        chk("mid_mul_busy", busy, 1);
        clr();
        chk("clr_state", tb_current_state, 0);
        chk("clr_busy", busy, 0);
        chk("clr_disp", display_output, 0);
        repeat (20) tick();
        chk("clr_no_result", complete, 0);

        enter(300);
        oper(3'd4);
        tick();
        enter(-4);
        equal_input = 1'b1;
        tick();
        equal_input = 1'b0;
        repeat (3) tick();
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        chk("nrst_state", tb_current_state, 0);
        chk("nrst_busy", busy, 0);
        chk("nrst_disp", display_output, 0);

        clr();
        for (int i = 0; i < 4; i++) key(4'd0);
        key(4'd1);
        key(4'd2);
        chk("max_digits", display_output, 1);
        clr();
        enter(3276);
        key(4'd8);
        chk("pos_limit", display_output, 3276);
        key(4'd7);
        chk("pos_max", display_output, 16'h7fff);
        key(4'hA);
        key(4'd9);
        chk("sixth_digit", display_output, 16'h7fff);
        clr();
        enter(-32768);
        chk("neg_min", display_output, 16'h8000);
        oper(3'd1);
        chk("neg_min_toggle", display_output, 16'h8000);
        clr();
        oper(3'd1);
        key(4'd5);
        chk("neg_first", display_output, 16'hfffb);

        repeat (3) tick();
        chk("sb_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/gencon_param.md
Name: gencon_param

Overview:
- Parametrised successor to the 16-bit calculator controller.
- Accepts BCD keypad digits, a sign toggle and an operator for two signed operands.
- Performs add, sub or mul on equal, and drives a signed result to the display path.
- Adds over the previous generation: configurable width, a sequential multiplier, overflow reporting, explicit clear, and result chaining (the result becomes operand A).

Parameters:
- DATA_W, 16: operand/result width, two's complement, >=8.
- MAX_DIGITS, 5: maximum decimal digits per operand entry.

Ports:
- clk  in  1  system clock
- nRST  in  1  synchronous active-low reset
- keypad_input  in  4  BCD digit, sampled when read_input=1
- read_input  in  1  digit strobe, one accept per high cycle
- operator_input  in  3  000 none, 001 negate, 010 add, 011 sub, 100 mul; others ignored
- equal_input  in  1  level; acted on only in S_ENTRY_B
- clear_input  in  1  level; returns to S_ENTRY_A with all values zeroed
- complete  out  1  high while in S_DONE
- busy  out  1  high while in S_EXEC
- overflow  out  1  result outside signed DATA_W range; valid in S_DONE
- display_output  out  DATA_W  signed current entry or result
- tb_current_state  out  3  encoded state, for bench observation

Behaviour:
- Clock and reset: one clock (clk); reset nRST is synchronous and active-low.
- Reset state: S_ENTRY_A, operands/op cleared. Outputs: complete=0, busy=0, overflow=0, display_output=0.
- States (encoding): S_ENTRY_A=0, S_OPER=1, S_EXEC=2, S_ENTRY_B=3, S_DONE=4.
- Input priority within one cycle: clear > equal > operator > digit.
- Digit entry:
  - Accepted in S_ENTRY_A/S_ENTRY_B when read_input=1 and keypad_input<=9: mag <= mag*10+digit.
  - display_output shows the signed entry the next cycle.
  - Ignored when keypad_input>9, when MAX_DIGITS is reached, or when the new magnitude would exceed 2^(DATA_W-1) (negative) or 2^(DATA_W-1)-1 (positive).
- Negate (001): toggles the entry sign in either entry state, allowed before any digit.
  - Toggling positive when mag=2^(DATA_W-1) is ignored.
- Operator (010/011/100):
  - In S_ENTRY_A: latch op, pass through S_OPER for one cycle, enter S_ENTRY_B with B=0.
  - In S_ENTRY_B: replaces op only if no B digit and no negate has occurred; otherwise ignored.
- Equal: in S_ENTRY_B moves to S_EXEC; ignored in all other states (a held level is harmless).
- S_EXEC:
  - add/sub: computed at DATA_W+1 bits, one cycle.
  - mul: sub-module, 2*DATA_W product, latency DATA_W+1 cycles from entry.
  - Then S_DONE.
- S_DONE:
  - display_output = result; complete=1; overflow=1 if the full-width result is out of range.
  - Default result is the wrapped low DATA_W bits.
- From S_DONE:
  - A digit starts a fresh S_ENTRY_A with that digit as the first digit.
  - add/sub/mul chains: A <= displayed result, op latched, go to S_ENTRY_B.
  - negate is ignored.
  - complete and overflow drop on exit.
- Clear in any state, including mid-multiply: aborts to reset values next cycle.
- nRST low mid-operation: same as clear.

Optional Feature:
- Macro: GENCON_SATURATE_EN.
- Defined: an out-of-range result is clamped to 2^(DATA_W-1)-1 or -2^(DATA_W-1); overflow is still asserted.
- Undefined: the result wraps to the low DATA_W bits.

Decomposition:
- Package gencon_param_pkg:
  - state_t enum with the encodings above.
  - op_t enum (OP_NONE, OP_NEG, OP_ADD, OP_SUB, OP_MUL).
  - Function for the signed range check.
- Sub-module gencon_seq_mult:
  - Signed shift-add multiplier, DATA_W iterations.
  - Interface start/done/abort plus operands and 2*DATA_W product.

Test Plan:
- 2, add, 3, equal -> complete within 3 cycles of equal, display=5, overflow=0.
- negate, 3,2,7,6,8; mul; 1; equal -> display=0x8000 (-32768); busy for 17 cycles; overflow=0.
- 128 mul 256 -> overflow=1, display=0x8000 (wrap) or 0x7FFF (GENCON_SATURATE_EN).
- -12 mul 3000 -> overflow=1, display=0x7360 (wrap) or 0x8000 (saturated).
- 5 sub 3 =, then add, 4, equal -> first 2, chained result 6; then digit 7 in S_DONE -> S_ENTRY_A with display=7.
- Clear asserted mid-mul, and digits pressed beyond MAX_DIGITS or magnitude 32768 positive -> state 0, display 0, busy 0; extra digits ignored.
